// File: rtl/sga_move_sequencer.sv
// Move sequencer for the Snake Game Arcade datapath: shift body, write head, check, grow, render.
// Optional feature macro: SGA_SELF_COLLISION_EN (define to make SHIFT_RD honour self_collision).
module sga_move_sequencer #(
    parameter int unsigned APPLE_RETRY_MAX = 63
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       step,
    input  logic       end_move,
    input  logic       render_finish,
    input  logic       self_collision,
    input  logic       wall_collision,
    input  logic       comeu_maca,
    input  logic       maca_na_cobra,
    output logic       busy,
    output logic       done,
    output logic       collided,
    output logic       ate,
    output logic       load_ram,
    output logic       counter_ram,
    output logic       we_ram,
    output logic       mux_ram,
    output logic       mux_ram_addres,
    output logic       mux_ram_render,
    output logic       register_head,
    output logic       count_size,
    output logic       register_apple,
    output logic       render_clr,
    output logic       render_count,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_HEAD       = 4'd1,
        S_LOAD       = 4'd2,
        S_SHIFT_RD   = 4'd3,
        S_SHIFT_WR   = 4'd4,
        S_CHECK      = 4'd5,
        S_WRITE_HEAD = 4'd6,
        S_GROW       = 4'd7,
        S_APPLE      = 4'd8,
        S_RENDER_CLR = 4'd9,
        S_RENDER     = 4'd10,
        S_FIN        = 4'd11
    } state_t;

`ifdef SGA_SELF_COLLISION_EN
    localparam logic SC_EN = 1'b1;
`else
    localparam logic SC_EN = 1'b0;
`endif

    localparam logic [7:0] RETRY_MAX = APPLE_RETRY_MAX[7:0];

    state_t     state_q, state_d;
    logic [7:0] retry_q, retry_d;
    logic       collided_q, collided_d;
    logic       ate_q, ate_d;
    logic       sc_hit;

    // Outputs are registered from the decode of the next state so they line up with state_q.
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic load_ram_q, load_ram_d;
    logic counter_ram_q, counter_ram_d;
    logic we_ram_q, we_ram_d;
    logic mux_ram_q, mux_ram_d;
    logic mux_addr_q, mux_addr_d;
    logic mux_render_q, mux_render_d;
    logic reg_head_q, reg_head_d;
    logic count_size_q, count_size_d;
    logic reg_apple_q, reg_apple_d;
    logic render_clr_q, render_clr_d;
    logic render_count_q, render_count_d;

    // A hit on the head's own cell (end_move=1) is the head itself, not a collision.
    assign sc_hit = SC_EN & self_collision & ~end_move;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        collided_d = collided_q;
        ate_d      = ate_q;
        case (state_q)
            S_IDLE: begin
                if (step) begin
                    collided_d = 1'b0;
                    ate_d      = 1'b0;
                    state_d    = S_HEAD;
                end
            end
            S_HEAD:     state_d = S_LOAD;
            S_LOAD:     state_d = S_SHIFT_RD;
            S_SHIFT_RD: begin
                if (sc_hit) begin
                    collided_d = 1'b1;
                    state_d    = S_FIN;
                end else if (end_move) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_SHIFT_WR;
                end
            end
            S_SHIFT_WR: state_d = S_SHIFT_RD;
            S_CHECK: begin
                if (wall_collision) begin
                    collided_d = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    if (comeu_maca) begin
                        ate_d = 1'b1;
                    end
                    state_d = S_WRITE_HEAD;
                end
            end
            S_WRITE_HEAD: state_d = ate_q ? S_GROW : S_RENDER_CLR;
            S_GROW: begin
                retry_d = 8'd0;
                state_d = S_APPLE;
            end
            S_APPLE: begin
                retry_d = retry_q + 8'd1;
                state_d = S_RENDER_CLR;
            end
            S_RENDER_CLR: state_d = S_RENDER;
            S_RENDER: begin
                // Once retries run out the apple is accepted where it lies.
                if (maca_na_cobra && ate_q && (retry_q < RETRY_MAX)) begin
                    state_d = S_APPLE;
                end else if (render_finish) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d         = 1'b1;
        done_d         = 1'b0;
        load_ram_d     = 1'b0;
        counter_ram_d  = 1'b0;
        we_ram_d       = 1'b0;
        mux_ram_d      = 1'b0;
        mux_addr_d     = 1'b0;
        mux_render_d   = 1'b0;
        reg_head_d     = 1'b0;
        count_size_d   = 1'b0;
        reg_apple_d    = 1'b0;
        render_clr_d   = 1'b0;
        render_count_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d       = 1'b0;
                render_clr_d = 1'b1;
            end
            S_HEAD: reg_head_d = 1'b1;
            S_LOAD: begin
                load_ram_d   = 1'b1;
                mux_render_d = 1'b1;
            end
            S_SHIFT_RD: mux_render_d = 1'b1;
            S_SHIFT_WR: begin
                we_ram_d      = 1'b1;
                mux_ram_d     = 1'b1;
                mux_addr_d    = 1'b1;
                mux_render_d  = 1'b1;
                counter_ram_d = 1'b1;
            end
            S_CHECK:      mux_render_d = 1'b1;
            S_WRITE_HEAD: begin
                we_ram_d     = 1'b1;
                mux_render_d = 1'b1;
            end
            S_GROW:       count_size_d   = 1'b1;
            S_APPLE:      reg_apple_d    = 1'b1;
            S_RENDER_CLR: render_clr_d   = 1'b1;
            S_RENDER:     render_count_d = 1'b1;
            S_FIN:        done_d         = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_q        <= S_IDLE;
            retry_q        <= 8'd0;
            collided_q     <= 1'b0;
            ate_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            load_ram_q     <= 1'b0;
            counter_ram_q  <= 1'b0;
            we_ram_q       <= 1'b0;
            mux_ram_q      <= 1'b0;
            mux_addr_q     <= 1'b0;
            mux_render_q   <= 1'b0;
            reg_head_q     <= 1'b0;
            count_size_q   <= 1'b0;
            reg_apple_q    <= 1'b0;
            render_clr_q   <= 1'b0;
            render_count_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            collided_q     <= collided_d;
            ate_q          <= ate_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            load_ram_q     <= load_ram_d;
            counter_ram_q  <= counter_ram_d;
            we_ram_q       <= we_ram_d;
            mux_ram_q      <= mux_ram_d;
            mux_addr_q     <= mux_addr_d;
            mux_render_q   <= mux_render_d;
            reg_head_q     <= reg_head_d;
            count_size_q   <= count_size_d;
            reg_apple_q    <= reg_apple_d;
            render_clr_q   <= render_clr_d;
            render_count_q <= render_count_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign collided       = collided_q;
    assign ate            = ate_q;
    assign load_ram       = load_ram_q;
    assign counter_ram    = counter_ram_q;
    assign we_ram         = we_ram_q;
    assign mux_ram        = mux_ram_q;
    assign mux_ram_addres = mux_addr_q;
    assign mux_ram_render = mux_render_q;
    assign register_head  = reg_head_q;
    assign count_size     = count_size_q;
    assign register_apple = reg_apple_q;
    assign render_clr     = render_clr_q;
    assign render_count   = render_count_q;
    assign db_estado      = state_q;

endmodule

// File: tb/tb_sga_move_sequencer.sv
// Self-checking bench for sga_move_sequencer: table vectors, corner sequences, random moves vs. a latency/outcome model.
module tb_sga_move_sequencer;

    localparam int MAXR = 3;

    logic clock = 1'b0;
    logic restart = 1'b1;
    logic step = 1'b0;
    logic end_move, render_finish, self_collision, wall_collision, comeu_maca, maca_na_cobra;
    logic busy, done, collided, ate, load_ram, counter_ram, we_ram, mux_ram, mux_ram_addres;
    logic mux_ram_render, register_head, count_size, register_apple, render_clr, render_count;
    logic [3:0] db_estado;

    int checks = 0;
    int failures = 0;

    // Environment: RAM address counter, render counter and snake size register.
    int addr = 0;
    int rcnt = 0;
    int sz = 1;
    int rd_cnt = 0;
    int size_init = 1;
    int sc_idx = 0;
    bit wall_cfg = 1'b0;
    bit apple_cfg = 1'b0;
    bit mnc_cfg = 1'b0;

    always #5 clock = ~clock;

    sga_move_sequencer #(.APPLE_RETRY_MAX(MAXR)) dut (
        .clock(clock), .restart(restart), .step(step), .end_move(end_move),
        .render_finish(render_finish), .self_collision(self_collision),
        .wall_collision(wall_collision), .comeu_maca(comeu_maca), .maca_na_cobra(maca_na_cobra),
        .busy(busy), .done(done), .collided(collided), .ate(ate), .load_ram(load_ram),
        .counter_ram(counter_ram), .we_ram(we_ram), .mux_ram(mux_ram),
        .mux_ram_addres(mux_ram_addres), .mux_ram_render(mux_ram_render),
        .register_head(register_head), .count_size(count_size), .register_apple(register_apple),
        .render_clr(render_clr), .render_count(render_count), .db_estado(db_estado)
    );

    always @(posedge clock) begin
        if (load_ram) addr <= sz;
        else if (counter_ram && addr > 0) addr <= addr - 1;
        if (render_clr) rcnt <= 0;
        else if (render_count) rcnt <= rcnt + 1;
        if (step && db_estado == 4'd0) begin
            sz     <= size_init;
            rd_cnt <= 0;
        end else begin
            if (count_size) sz <= sz + 1;
            if (db_estado == 4'd3) rd_cnt <= rd_cnt + 1;
        end
    end

    assign end_move       = (addr == 0);
    assign render_finish  = (rcnt == sz);
    assign self_collision = (db_estado == 4'd3) && (rd_cnt + 1 == sc_idx);
    assign wall_collision = wall_cfg;
    assign comeu_maca     = apple_cfg;
    assign maca_na_cobra  = mnc_cfg;

    typedef struct {
        int n; int w; int a; int s; int m;
        int lat; int col; int ate; int we; int apl; int grow;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: move latency (step cycle counted as 1) and outcome from the move rules.
    task automatic model(input int n, input int w, input int a, input int s, input int m,
                         output int lat, output int col, output int at, output int we,
                         output int apl, output int grow);
        int sc_en;
        int k;
`ifdef SGA_SELF_COLLISION_EN
        sc_en = 1;
`else
        sc_en = 0;
`endif
        col = 0; at = 0; apl = 0; grow = 0;
        if (sc_en != 0 && s >= 1 && s <= n) begin
            lat = 2 * s + 3; col = 1; we = s - 1;
        end else if (w != 0) begin
            lat = 2 * n + 6; col = 1; we = n;
        end else if (a == 0) begin
            lat = 3 * n + 9; we = n + 1;
        end else begin
            k    = (m != 0) ? MAXR : 1;
            lat  = (2 * n + 6) + 1 + 2 * k + (k - 1) + (n + 2) + 1;
            we   = n + 1; apl = k; grow = 1; at = 1;
        end
    endtask

    task automatic do_move(input string tag, input int n, input int w, input int a, input int s,
                           input int m, input int extra, input int elat, input int ecol,
                           input int eate, input int ewe, input int eapl, input int egrow);
        int cyc, nwe, napl, ngrow, blow, idle_busy, got, rcol, rate;
        @(negedge clock);
        size_init = n; wall_cfg = (w != 0); apple_cfg = (a != 0); mnc_cfg = (m != 0); sc_idx = s;
        step = 1'b1;
        cyc = 1; nwe = 0; napl = 0; ngrow = 0; blow = 0; got = 0; rcol = 0; rate = 0;
        while (cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            step = (cyc == extra);
            if (we_ram) nwe++;
            if (register_apple) napl++;
            if (count_size) ngrow++;
            if (!busy) blow++;
            if (done) begin
                got = 1; rcol = collided; rate = ate;
                break;
            end
        end
        chk({tag, " done_seen"}, got, 1);
        chk({tag, " latency"}, cyc, elat);
        chk({tag, " collided"}, rcol, ecol);
        chk({tag, " ate"}, rate, eate);
        chk({tag, " we_ram_pulses"}, nwe, ewe);
        chk({tag, " apple_pulses"}, napl, eapl);
        chk({tag, " grow_pulses"}, ngrow, egrow);
        chk({tag, " busy_gaps"}, blow, 0);
        @(posedge clock); #1;
        step = 1'b0;
        chk({tag, " done_one_cycle"}, int'(done), 0);
        chk({tag, " back_idle"}, int'(db_estado), 0);
        chk({tag, " collided_held"}, int'(collided), ecol);
        chk({tag, " ate_held"}, int'(ate), eate);
        idle_busy = int'(busy);
        repeat (2) begin
            @(posedge clock); #1;
            if (busy) idle_busy++;
        end
        chk({tag, " idle_after"}, idle_busy, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        do_move(tag, v.n, v.w, v.a, v.s, v.m, 0, v.lat, v.col, v.ate, v.we, v.apl, v.grow);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, col, at, we, apl, grow, n, w, a, s, m, waited, wr_after;
        //           n  w  a  s  m  lat col ate we apl grow
        tbl[0] = '{1, 0, 0, 0, 0, 12, 0, 0, 2, 0, 0};
        tbl[1] = '{3, 0, 1, 0, 0, 21, 0, 1, 4, 1, 1};
        tbl[2] = '{3, 1, 1, 0, 0, 12, 1, 0, 3, 0, 0};
        tbl[3] = '{2, 0, 1, 0, 1, 24, 0, 1, 3, 3, 1};
        tbl[4] = '{5, 0, 0, 0, 0, 24, 0, 0, 6, 0, 0};
        tbl[5] = '{4, 1, 0, 0, 1, 14, 1, 0, 4, 0, 0};
`ifdef SGA_SELF_COLLISION_EN
        tbl[6] = '{3, 0, 0, 2, 0, 7, 1, 0, 1, 0, 0};
`else
        tbl[6] = '{3, 0, 0, 2, 0, 18, 0, 0, 4, 0, 0};
`endif
        tbl[7] = '{2, 0, 0, 3, 0, 15, 0, 0, 3, 0, 0};

        // Reset state.
        #1;
        chk("reset_outputs", int'({busy, done, collided, ate, load_ram, counter_ram, we_ram, mux_ram,
            mux_ram_addres, mux_ram_render, register_head, count_size, register_apple,
            render_clr, render_count}), 0);
        chk("reset_state", int'(db_estado), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        restart = 1'b0;
        @(posedge clock); #1;
        chk("idle_render_clr", int'(render_clr), 1);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Step while busy and step during FIN are both dropped.
        do_move("step_busy", 2, 0, 0, 0, 0, 5, 15, 0, 0, 3, 0, 0);
        do_move("step_fin", 2, 0, 0, 0, 0, 15, 15, 0, 0, 3, 0, 0);

        // Restart in the middle of a body shift.
        @(negedge clock);
        size_init = 4; wall_cfg = 1'b0; apple_cfg = 1'b0; mnc_cfg = 1'b0; sc_idx = 0;
        step = 1'b1;
        waited = 0;
        @(posedge clock); #1;
        step = 1'b0;
        while (db_estado != 4'd4 && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        chk("reach_shift_wr", int'(db_estado), 4);
        restart = 1'b1;
        #1;
        chk("abort_outputs", int'({busy, done, collided, ate, load_ram, counter_ram, we_ram, mux_ram,
            mux_ram_addres, mux_ram_render, register_head, count_size, register_apple,
            render_clr, render_count}), 0);
        chk("abort_state", int'(db_estado), 0);
        wr_after = 0;
        repeat (2) begin
            @(posedge clock); #1;
            if (we_ram) wr_after++;
        end
        chk("abort_no_write", wr_after, 0);
        @(negedge clock);
        restart = 1'b0;
        @(posedge clock); #1;
        chk("abort_idle", int'(busy), 0);
        run_vec("after_abort", tbl[0]);

        // Random moves against the model.
        for (int i = 0; i < 30; i++) begin
            n = int'($urandom_range(1, 6));
            w = ($urandom_range(0, 3) == 0) ? 1 : 0;
            a = int'($urandom_range(0, 1));
            s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n + 1)) : 0;
            m = int'($urandom_range(0, 1));
            model(n, w, a, s, m, lat, col, at, we, apl, grow);
            do_move($sformatf("rnd%0d", i), n, w, a, s, m, 0, lat, col, at, we, apl, grow);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
